hit_detector: RTL and testbench
===============================

# hit_detector

Frame-energy drum-hit detector sitting directly downstream of the delay/echo stage. Consumes the 12-bit signed 24 kHz sample stream and that stage's level-style done flag, sums sample magnitudes over fixed 10 ms frames (240 samples), and emits a one-cycle hit pulse on each rising crossing of a programmable energy threshold, followed by a hold-off window. Frame energy and peak are exported for display and for the downstream sound-classification logic.

## Interface
- WINDOW, 240, samples per frame (10 ms at 24 kHz); legal range 2..255
- HOLDOFF_FRAMES, 5, frames after a hit during which further hits are suppressed; legal range 0..15
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- sample_done  input  1  level flag from upstream stage; a new sample is valid on its rising edge
- sample  input  12  signed two's-complement sample, stable while sample_done is high
- threshold  input  19  unsigned energy threshold; 0 disables hit generation
- frame_energy  output  19  sum of magnitudes of the last completed frame (registered)
- frame_peak  output  11  largest magnitude in the last completed frame (registered)
- frame_valid  output  1  one-cycle pulse when frame_energy/frame_peak update
- hit  output  1  one-cycle pulse, coincident with frame_valid, marking a detected hit
- holdoff_active  output  1  high while hold-off counter is nonzero

## Operation
- Clock is `clock`; reset is `reset`, asynchronous, active-low. While reset is low, all registers and outputs are 0, state is IDLE.
- Edge detect: register sample_done every cycle; new sample = sample_done high and its registered copy low. Registered copy resets to 0, so sample_done high at reset release counts as one edge.
- Magnitude: |sample|, 11 bits; -2048 saturates to 2047.
- State machine:
- IDLE: on new-sample edge capture magnitude, go ACCUM; otherwise stay.
- ACCUM (1 cycle): acc += mag; peak = max(peak, mag); count += 1. If count reaches WINDOW go FRAME_END, else IDLE.
- FRAME_END (1 cycle): load frame_energy <= acc, frame_peak <= peak; pulse frame_valid; evaluate hit; clear acc, peak, count; go IDLE.
- Width: acc is 19 bits; max 255*2047 = 521985 < 2^19, no overflow possible within legal WINDOW.
- Hit rule, evaluated in FRAME_END on the new acc: hit = (threshold != 0) and (acc >= threshold) and (prev_above == 0) and (holdoff counter == 0). prev_above <= (acc >= threshold) every frame, regardless of hold-off.
- Hold-off: on hit, counter loads HOLDOFF_FRAMES; otherwise, if nonzero, decrements by 1 in each FRAME_END. holdoff_active = counter != 0.
- An edge arriving while in ACCUM or FRAME_END is dropped (upstream guarantees edges at least 4 cycles apart).
- Threshold change takes effect at the next FRAME_END; no other effect.

## Timing
- New-sample edge detected at clock edge k -> accumulation at edge k+1 -> if frame complete, frame_valid/hit/frame_energy/frame_peak update at edge k+2.
- frame_valid and hit are high for exactly one cycle; frame_energy/frame_peak hold until the next frame.
- Minimum edge spacing for lossless operation: 3 cycles.
- Reset asserted mid-frame: partial frame discarded, hold-off and prev_above cleared; first frame after release starts at count 0.
- No outputs are combinational from inputs.

## Test plan
- WINDOW=4: samples 100, -200, 300, -2048 on done edges spaced 4 cycles -> frame_valid once, 2 cycles after 4th edge; frame_energy=2647, frame_peak=2047.
- WINDOW=4, threshold=1000: frames of magnitude 100,100,400,400 (energy 1000) -> hit=1 on that frame; identical following frame -> hit=0 (no rising crossing).
- WINDOW=4, HOLDOFF_FRAMES=2, threshold=1000: frame energies 1000, 0, 1000, 0, 0, 1000 -> hits on frames 1 and 6 only; frame 3 suppressed; holdoff_active high across frames 1-2 end.
- threshold=0 with full-scale input -> frame_valid pulses, hit never asserted.
- sample_done held high 20 cycles -> exactly one sample accumulated; reset pulled low after 2 of 4 samples -> all outputs 0 immediately; after release, next 4 samples of 50 give frame_energy=200.

Source files
------------

// File: rtl/hit_detector.sv
// Frame-energy hit detector: sums |sample| over WINDOW samples, pulses hit on rising threshold crossing.
// Latency: frame outputs update 2 cycles after the last sample edge; no backpressure, edges during ACCUM/FRAME_END are dropped.
module hit_detector #(
  parameter int WINDOW         = 240,
  parameter int HOLDOFF_FRAMES = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_done,
  input  logic [11:0] sample,
  input  logic [18:0] threshold,
  output logic [18:0] frame_energy,
  output logic [10:0] frame_peak,
  output logic        frame_valid,
  output logic        hit,
  output logic        holdoff_active
);

  typedef enum logic [1:0] {IDLE, ACCUM, FRAME_END} state_t;

  state_t      state;
  logic        done_q;
  logic [10:0] mag_q;
  logic [18:0] acc;
  logic [10:0] peak;
  logic [7:0]  count;
  logic        prev_above;
  logic [3:0]  hold_cnt;

  logic        new_sample;
  logic [11:0] neg_sample;
  logic [10:0] mag;
  logic [7:0]  count_nxt;
  logic        above;
  logic        hit_now;

  assign new_sample = sample_done && !done_q;
  assign neg_sample = ~sample + 12'd1;
  assign count_nxt  = count + 8'd1;

  // -2048 has no positive 12-bit counterpart, so it clamps to full scale.
  always_comb begin
    mag = sample[10:0];
    if (sample[11]) begin
      if (sample == 12'h800) mag = 11'h7ff;
      else                   mag = neg_sample[10:0];
    end
  end

  assign above   = (acc >= threshold);
  assign hit_now = (threshold != 19'd0) && above && !prev_above && (hold_cnt == 4'd0);

  assign holdoff_active = (hold_cnt != 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      mag_q        <= '0;
      acc          <= '0;
      peak         <= '0;
      count        <= '0;
      prev_above   <= 1'b0;
      hold_cnt     <= '0;
      frame_energy <= '0;
      frame_peak   <= '0;
      frame_valid  <= 1'b0;
      hit          <= 1'b0;
    end else begin
      done_q      <= sample_done;
      frame_valid <= 1'b0;
      hit         <= 1'b0;
      case (state)
        IDLE: begin
          if (new_sample) begin
            mag_q <= mag;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc   <= acc + {8'd0, mag_q};
          if (mag_q > peak) peak <= mag_q;
          count <= count_nxt;
          state <= (count_nxt == 8'(WINDOW)) ? FRAME_END : IDLE;
        end
        FRAME_END: begin
          frame_energy <= acc;
          frame_peak   <= peak;
          frame_valid  <= 1'b1;
          hit          <= hit_now;
          // prev_above tracks the raw crossing even while hold-off masks hits.
          prev_above   <= above;
          if (hit_now)               hold_cnt <= 4'(HOLDOFF_FRAMES);
          else if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
          acc   <= '0;
          peak  <= '0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector with WINDOW=4, HOLDOFF_FRAMES=2.
module tb_hit_detector;

  logic        clock;
  logic        reset;
  logic        sample_done;
  logic [11:0] sample;
  logic [18:0] threshold;
  logic [18:0] frame_energy;
  logic [10:0] frame_peak;
  logic        frame_valid;
  logic        hit;
  logic        holdoff_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_edge_cyc = 0;
  int stray_hits = 0;

  int q_energy[$];
  int q_peak[$];
  int q_hit[$];
  int q_hold[$];
  int q_cyc[$];

  hit_detector #(.WINDOW(4), .HOLDOFF_FRAMES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .sample_done    (sample_done),
    .sample         (sample),
    .threshold      (threshold),
    .frame_energy   (frame_energy),
    .frame_peak     (frame_peak),
    .frame_valid    (frame_valid),
    .hit            (hit),
    .holdoff_active (holdoff_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (frame_valid) begin
      q_energy.push_back(int'(frame_energy));
      q_peak.push_back(int'(frame_peak));
      q_hit.push_back(int'(hit));
      q_hold.push_back(int'(holdoff_active));
      q_cyc.push_back(cyc);
    end
    if (hit && !frame_valid) stray_hits++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_energy.delete(); q_peak.delete(); q_hit.delete(); q_hold.delete(); q_cyc.delete();
  endtask

  // One rising edge of sample_done; next call's edge lands 4 cycles later.
  task automatic send(input int v);
    @(posedge clock); #1;
    sample      = 12'(v);
    sample_done = 1'b1;
    @(posedge clock); #1;
    last_edge_cyc = cyc;
    @(posedge clock); #1;
    sample_done = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic expect_frame(input string tag, input int e, input int p, input int h, input int ho);
    check({tag, "_frames"}, q_energy.size(), 1);
    if (q_energy.size() > 0) begin
      check({tag, "_energy"}, q_energy[0], e);
      check({tag, "_peak"},   q_peak[0],   p);
      check({tag, "_hit"},    q_hit[0],    h);
      check({tag, "_holdoff"}, q_hold[0],  ho);
      check({tag, "_latency"}, q_cyc[0] - last_edge_cyc, 2);
    end
    clear_q();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_energy"},  frame_energy,   0);
    check({tag, "_peak"},    frame_peak,     0);
    check({tag, "_valid"},   frame_valid,    0);
    check({tag, "_hit"},     hit,            0);
    check({tag, "_holdoff"}, holdoff_active, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    clear_q();
  endtask

  initial begin
    reset       = 1'b0;
    sample_done = 1'b0;
    sample      = '0;
    threshold   = '0;
    #23;
    check_zero("por");
    reset = 1'b1;

    // Mixed signs, -2048 clamps to 2047: 100+200+300+2047.
    send4(100, -200, 300, -2048);
    expect_frame("basic", 2647, 2047, 0, 0);

    // Rising crossing hits once; an identical following frame does not.
    do_reset();
    threshold = 19'd1000;
    send4(100, -100, 400, -400);
    expect_frame("rise1", 1000, 400, 1, 1);
    send4(100, 100, 400, 400);
    expect_frame("rise2", 1000, 400, 0, 1);

    // Hold-off of 2 frames suppresses the crossing in frame 3.
    do_reset();
    threshold = 19'd1000;
    send4(100, 100, 400, 400); expect_frame("ho_f1", 1000, 400, 1, 1);
    send4(0, 0, 0, 0);         expect_frame("ho_f2", 0, 0, 0, 1);
    send4(100, 100, 400, 400); expect_frame("ho_f3", 1000, 400, 0, 0);
    send4(0, 0, 0, 0);         expect_frame("ho_f4", 0, 0, 0, 0);
    send4(0, 0, 0, 0);         expect_frame("ho_f5", 0, 0, 0, 0);
    send4(100, 100, 400, 400); expect_frame("ho_f6", 1000, 400, 1, 1);

    // Threshold 0 disables hits even at full scale.
    do_reset();
    threshold = 19'd0;
    send4(2047, -2047, -2048, 2047);
    expect_frame("fs1", 8188, 2047, 0, 0);
    send4(-2048, -2048, -2048, -2048);
    expect_frame("fs2", 8188, 2047, 0, 0);

    // A level held high for 20 cycles is a single sample.
    do_reset();
    @(posedge clock); #1;
    sample      = 12'd50;
    sample_done = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    sample_done = 1'b0;
    @(posedge clock); #1;
    check("held_noframe", q_energy.size(), 0);
    send(50); send(50);
    check("held_partial", q_energy.size(), 0);
    send(50);
    expect_frame("held", 200, 50, 0, 0);

    // Reset mid-frame discards the partial sum and clears outputs at once.
    send(300); send(-300);
    @(posedge clock); #1;
    reset = 1'b0;
    #2;
    check_zero("midrst");
    @(posedge clock); #1;
    reset = 1'b1;
    clear_q();
    send(50); send(-50);
    check("midrst_partial", q_energy.size(), 0);
    send(50); send(-50);
    expect_frame("after_rst", 200, 50, 0, 0);

    check("stray_hits", stray_hits, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
